// File: rtl/seq_mult_ctrl_if.sv
// Handshake and data bundle between the top-level controller and the
// sequential multiplier core. The controller drives start/a/b; the core
// returns the product with a done pulse and a busy level.
// Optional macro MULT_BUSY_ERR_EN adds the err pulse to the bundle.
interface seq_mult_ctrl_if #(parameter int WIDTH = 4);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   product;
  logic                 done;
  logic                 busy;
`ifdef MULT_BUSY_ERR_EN
  logic                 err;

  modport master (output start, a, b, input product, done, busy, err);
  modport slave  (input start, a, b, output product, done, busy, err);
`else
  modport master (output start, a, b, input product, done, busy);
  modport slave  (input start, a, b, output product, done, busy);
`endif
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier core: captures a/b on an accepted start,
// then spends WIDTH cycles adding the (mux-selected) multiplicand into the
// accumulator and shifting {acc,q} right one bit per cycle. The final
// {acc,q} is the unsigned 2*WIDTH-bit product, published with a done pulse.
// Optional macro MULT_BUSY_ERR_EN: adds an err pulse when start arrives
// while an operation is already running.
module seq_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  seq_mult_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     q;
  logic [WIDTH:0]       acc;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_r;
  logic                 done_r;
  logic                 busy_r;
`ifdef MULT_BUSY_ERR_EN
  logic                 err_r;
`endif

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     shifted;

  // One iteration of the datapath: the q LSB selects the addend, the add
  // keeps its carry, and the carry/sum pair shifts into {acc,q}. acc's top
  // bit is always zero after a shift, so adding the full acc is the same as
  // adding its low WIDTH bits.
  always_comb begin
    addend  = q[0] ? m : '0;
    sum     = acc + {1'b0, addend};
    shifted = {sum, q} >> 1;
  end

  // Control FSM, iteration counter, operand registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m         <= '0;
      q         <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_r <= '0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
`ifdef MULT_BUSY_ERR_EN
      err_r     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
`ifdef MULT_BUSY_ERR_EN
      err_r  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            m      <= bus.a;
            q      <= bus.b;
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= shifted[2*WIDTH:WIDTH];
          q   <= shifted[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            product_r <= shifted[2*WIDTH-1:0];
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end
`ifdef MULT_BUSY_ERR_EN
          err_r <= bus.start;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.product = product_r;
  assign bus.done    = done_r;
  assign bus.busy    = busy_r;
`ifdef MULT_BUSY_ERR_EN
  assign bus.err     = err_r;
`endif

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Sequential shift-add multiplier core for the 4x4 multiplier: an FSM, an iteration counter, and operand/accumulator registers.
- Produces a 2*WIDTH-bit unsigned product over WIDTH iteration cycles.
- Sits directly downstream of the 1-bit mux cells. Per bit, the core generates the mux select (the multiplier LSB), which chooses the addend between 0 and the multiplicand; the core then consumes the mux output in its adder/shift register.
- Start/done handshake toward the top-level controller.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand, captured when start is accepted
b  input  WIDTH  multiplier, captured when start is accepted
product  output  2*WIDTH  last completed result, held until next completion
done  output  1  one-cycle pulse: product just updated
busy  output  1  high while an operation is in progress

Behaviour:
- Reset (async, rst=1): state=IDLE; product=0, done=0, busy=0; internal regs M, Q, ACC (WIDTH+1 bits incl. carry) and cnt all cleared.
- States: IDLE, RUN.
- IDLE, start=1 at edge k (start accepted):
  - M<=a, Q<=b, ACC<=0, cnt<=0.
  - state<=RUN, busy<=1.
- IDLE, start=0: hold all registers; busy=0.
- RUN, each edge:
  - addend = Q[0] ? M : 0 (mux stage, sel=Q[0]).
  - sum = ACC[WIDTH-1:0] + addend, WIDTH+1 bits, carry kept.
  - Right shift of the concatenation: {ACC,Q} <= {sum,Q} >> 1. Carry enters the MSB; the sum LSB enters Q MSB.
  - cnt<=cnt+1.
- Last iteration, at the edge where cnt==WIDTH-1 (edge k+WIDTH):
  - product <= shifted {ACC[WIDTH-1:0],Q}, i.e. the final value.
  - done<=1, busy<=0, state<=IDLE.
- Latency: start sampled at edge k; done is high for exactly one cycle after edge k+WIDTH+... precisely, after edge k+WIDTH (WIDTH+1 edges total). For WIDTH=4: 5 edges.
- done is registered and deasserts at the next edge unless another completion occurs. Back-to-back completions are impossible, since minimum spacing is WIDTH+1.
- start while busy=1 (RUN): ignored; operands are not recaptured and the running operation is unaffected.
- start high in the cycle done=1: accepted (state is IDLE). product keeps the old result until the new completion.
- start held high continuously: a new operation begins on every IDLE cycle, giving a WIDTH+1 cycle period.
- Reset mid-RUN: immediate abort. All outputs return to reset values; no done pulse is generated.
- Arithmetic is unsigned. Product is exact for all inputs, max (2^WIDTH-1)^2; no overflow is possible.
- cnt width: clog2(WIDTH)+1 bits; no wrap-around inside RUN.

Optional Feature:
Macro MULT_BUSY_ERR_EN.
- Defined:
  - Adds output port err (1 bit), reset 0.
  - err is a registered one-cycle pulse on the edge after start=1 is sampled while state=RUN.
  - Sticky behaviour is not provided.
  - The operation in progress is unaffected.
- Undefined: port err is absent. start during RUN is silently ignored. All other behaviour is identical.

Test Plan:
- Reset, then a=13, b=11, start pulse 1 cycle -> busy high 4 cycles; done pulses once 5 edges after start; product=143.
- a=15, b=15 -> product=225 (maximum, carry path exercised). Then a=0, b=9 -> product=0, done still pulses after 5 edges.
- a=7, b=6 with start held high through done, a/b switched to 3/5 in the done cycle -> product=42 at the first done, 15 at the second done 5 edges later.
- Start a=9, b=9; after 2 RUN edges, assert start with a=1, b=1 -> ignored; product=81. With MULT_BUSY_ERR_EN, err pulses exactly once.
- Start a=12, b=10; assert rst asynchronously mid-RUN (between edges) -> busy=0, done=0, product=0 immediately; no done pulse afterwards. A new start with a=2, b=3 -> product=6.
- Exhaustive sweep over all 256 a/b pairs, each compared to a*b at done -> zero mismatches.
